// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard, branch operand waits,
// multi-cycle front-end flush after a taken branch, and saturating statistics.
module hazard_scoreboard #(
   parameter int NUM_REGS    = 32,
   parameter int REG_W       = 5,
   parameter int ALU_LAT     = 1,
   parameter int LOAD_LAT    = 2,
   parameter int CNT_W       = 2,
   parameter int FLUSH_DEPTH = 1,
   parameter int STAT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_branch,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              branch_taken,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              stall,
   output logic              ifid_flush,
   output logic [STAT_W-1:0] stall_count,
   output logic [STAT_W-1:0] flush_count
);

   localparam int HOLD_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

   logic [CNT_W-1:0]  cnt_q [NUM_REGS];
   logic [CNT_W-1:0]  cnt_d [NUM_REGS];
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             hold;
   logic [CNT_W-1:0] slack;
   logic             haz_rs1, haz_rs2;
   logic             stall_raw, issue, taken, flush_raw;

   always_comb begin
      hold  = (hold_q != '0);
      // Branches compare in ID, so they cannot use EX->EX forwarding.
      slack = id_branch ? '0 : CNT_W'(ALU_LAT);
      haz_rs1 = id_use_rs1 && (id_rs1 != '0) && (cnt_q[id_rs1] > slack);
      haz_rs2 = id_use_rs2 && (id_rs2 != '0) && (cnt_q[id_rs2] > slack);
      stall_raw = id_valid && !hold && (haz_rs1 || haz_rs2);
      issue     = id_valid && !stall_raw && !hold;
      taken     = branch_taken && !stall_raw && !hold;
      flush_raw = taken || hold;

      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
         if (r != 0 && issue && id_reg_write && id_rd == REG_W'(r))
            cnt_d[r] = id_mem_read ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
      end
      cnt_d[0] = '0;

      if (taken)
         hold_d = HOLD_W'(FLUSH_DEPTH - 1);
      else if (hold)
         hold_d = hold_q - HOLD_W'(1);
      else
         hold_d = hold_q;

      stall_cnt_d = (stall_raw && stall_cnt_q != '1) ? stall_cnt_q + STAT_W'(1) : stall_cnt_q;
      flush_cnt_d = (flush_raw && flush_cnt_q != '1) ? flush_cnt_q + STAT_W'(1) : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
         hold_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
         hold_q      <= hold_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Control outputs are forced inactive for the whole time reset is asserted.
   assign stall       = rst_n && stall_raw;
   assign pc_write    = rst_n && !stall_raw;
   assign ifid_write  = rst_n && !stall_raw;
   assign ifid_flush  = rst_n && flush_raw;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard/flush logic of the in-order RISC-V pipeline.
- Replaces the single EX-stage Rd comparison with a per-register countdown scoreboard, so variable producer latencies (ALU, load, deeper memory) are handled generically.
- Handles branch-in-ID operand waits and multi-cycle front-end flush after a taken branch.
- Sits beside the ID stage; drives PC write enable, IF/ID write enable, ID/EX bubble insert and IF/ID flush; exposes saturating stall/flush statistics counters.

Parameters:
- NUM_REGS, 32, architectural registers tracked (x0 never tracked).
- REG_W, 5, register index width, clog2(NUM_REGS).
- ALU_LAT, 1, scoreboard value loaded for a non-load producer.
- LOAD_LAT, 2, scoreboard value loaded for a load producer (must be >= ALU_LAT).
- CNT_W, 2, per-register counter width (must hold LOAD_LAT).
- FLUSH_DEPTH, 1, cycles flush is held after a taken branch (>= 1).
- STAT_W, 16, statistics counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  REG_W  source 1 index.
- id_rs2  in  REG_W  source 2 index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_branch  in  1  instruction is a branch resolved in ID.
- id_rd  in  REG_W  destination index.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- branch_taken  in  1  ID branch resolved taken (PCSrc).
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- stall  out  1  insert bubble into ID/EX.
- ifid_flush  out  1  clear IF/ID register.
- stall_count  out  STAT_W  stall cycles since reset, saturating.
- flush_count  out  STAT_W  flush cycles since reset, saturating.

Behaviour:
- Reset (async, rst_n=0): all scoreboard counters 0, flush-hold counter 0, stall_count=0, flush_count=0. While rst_n=0, outputs are forced to pc_write=0, ifid_write=0, stall=0, ifid_flush=0.
- Scoreboard: cnt[r], one counter per register r=1..NUM_REGS-1; cnt[0] is constant 0.
  - Each clock, every nonzero cnt decrements by 1.
  - An issue writing rd overrides the decrement for that rd, loading (id_mem_read ? LOAD_LAT : ALU_LAT).
- Hold: hold = (flush-hold counter != 0).
- Source hazard: src_haz(rs,use) = use && rs!=0 && cnt[rs] > slack.
  - slack = 0 when id_branch=1.
  - slack = ALU_LAT otherwise (EX->EX forwarding covers ALU results).
- Stall: stall_raw = id_valid && !hold && (src_haz(rs1) || src_haz(rs2)).
- Combinational outputs (rst_n=1): stall = stall_raw; pc_write = ifid_write = !stall_raw.
- Issue: issue = id_valid && !stall_raw && !hold. Scoreboard is written only on issue with id_reg_write=1 and id_rd!=0.
- Taken branch: taken = branch_taken && !stall_raw && !hold. A stalled or held branch is ignored.
- ifid_flush = taken || hold. On taken, the flush-hold counter loads FLUSH_DEPTH-1; otherwise it decrements while nonzero.
  - During hold, ID contents are wrong-path: no issue, no stall, no scoreboard write.
- Latency with default parameters:
  - Load-use to ALU consumer: 1 bubble.
  - ALU to ALU consumer: 0 bubbles.
  - ALU to branch: 1 bubble.
  - Load to branch: 2 bubbles.
- WAW: a later issue to the same rd simply reloads cnt[rd] (in-order pipeline).
- Statistics:
  - stall_count increments on each cycle stall=1.
  - flush_count increments on each cycle ifid_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-hold: all state is cleared immediately; after release the first instruction sees no hazard.

Test Plan:
- Load x5 issued, next cycle ALU add reads x5 -> stall=1, pc_write=0, ifid_write=0 for exactly 1 cycle; then issue; stall_count=1.
- ALU writes x7, next cycle beq reads x7 -> stall 1 cycle; load writes x7 then beq reads x7 -> stall 2 cycles; stall_count=3 total.
- Producer rd=x0 (load), consumer reads x0 -> no stall; also any consumer with id_use_rs*=0 on a pending register -> no stall.
- FLUSH_DEPTH=3: beq not stalled, branch_taken=1 -> ifid_flush=1 for 3 consecutive cycles. A load with rd=x9 presented with id_valid=1 during hold leaves cnt[9]=0; flush_count=3.
- branch_taken=1 while the same branch stalls on a load operand -> ifid_flush=0 that cycle; flush is asserted once the branch issues.
- Assert rst_n=0 mid-load-stall with cnt[5]=2 -> outputs forced immediately; after release, an ALU reading x5 issues with stall=0. Separately, force stall_count to all-ones via a long stall -> holds at all-ones.
